dm_wait_mem: RTL and testbench
==============================

DM_WAIT_MEM -- requirements
Module: dm_wait_mem

Interface
- REQ-001 The block SHALL have parameter AW, default 13, meaning data-memory address width in bits.
- REQ-002 The block SHALL have parameter DW, default 16, meaning data width in bits.
- REQ-003 The block SHALL have parameter DEPTH, default 8192, meaning number of words (1..2^AW).
- REQ-004 The block SHALL have parameter WAIT, default 2, meaning wait states per access (0..15).
- REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-007 The block SHALL have port rd_mem, input, 1 bit: read request, held high until dm_ready.
- REQ-008 The block SHALL have port wr_mem, input, 1 bit: write request, held high until dm_ready.
- REQ-009 The block SHALL have port dm_abus, input, AW bits: word address.
- REQ-010 The block SHALL have port dm_in_dbus, input, DW bits: write data.
- REQ-011 The block SHALL have port dm_out_dbus, output, DW bits: registered read data.
- REQ-012 The block SHALL have port dm_ready, output, 1 bit: one-cycle transaction-complete pulse.
- REQ-013 The block SHALL have port dm_busy, output, 1 bit: high in every state except IDLE.
- REQ-014 The block SHALL have port dm_err, output, 1 bit: range error; driven constant 0 when DM_RANGE_CHECK_EN is undefined.

Function
- REQ-015 The block SHALL implement FSM states IDLE, WAIT and DONE.
- REQ-016 In IDLE, a rising edge with rd_mem or wr_mem high SHALL capture address, write data and operation, and load the wait counter with WAIT.
- REQ-017 From IDLE, the FSM SHALL go to WAIT if WAIT>0, else directly to DONE.
- REQ-018 In WAIT, the counter SHALL decrement each cycle, with the FSM going to DONE on the edge where the counter equals 1.
- REQ-019 The FSM SHALL go from DONE to IDLE unconditionally.
- REQ-020 dm_ready SHALL be high only in DONE, exactly WAIT+1 cycles after the capturing edge.
- REQ-021 The array SHALL be written with captured data on the edge entering DONE.
- REQ-022 For reads, dm_out_dbus SHALL be loaded from the array on the edge entering DONE and held until the next read completes.
- REQ-023 When rd_mem and wr_mem are both high at capture, the block SHALL perform the write only.
- REQ-024 Request and bus inputs SHALL be ignored outside IDLE; the captured values SHALL be used.
- REQ-025 The master SHALL drop its request on the edge ending the dm_ready cycle; a request high in the following IDLE cycle starts a new transaction, giving a throughput of one access per WAIT+2 cycles.
- REQ-026 A read after a write to the same address SHALL return the written data.

Reset
- REQ-027 While reset is low, the state SHALL be IDLE, the counter 0, dm_ready=0, dm_busy=0, dm_err=0 and dm_out_dbus=0, asynchronously.
- REQ-028 Reset mid-transaction SHALL discard the captured access with no array write; array contents SHALL NOT be cleared.

Configuration
- REQ-029 With macro DM_RANGE_CHECK_EN defined, a captured address >= DEPTH SHALL still complete the full handshake, assert dm_err together with dm_ready for that cycle, suppress the array write, and return 0 on dm_out_dbus for a read.
- REQ-030 Without DM_RANGE_CHECK_EN, the address SHALL be used modulo the array index width, with no error output logic.

Verification
- REQ-031 WAIT=2: write 0x1234 to 0x0005, then read 0x0005 -> dm_ready 3 cycles after each capture; dm_out_dbus=0x1234.
- REQ-032 WAIT=0: back-to-back writes to 0x0000/0x0001 then reads -> one access per 2 cycles; data 0xAAAA/0x5555 returned.
- REQ-033 rd_mem and wr_mem both high, data 0x00FF, address 0x0010 -> write performed; a later read returns 0x00FF; dm_out_dbus unchanged at the collision's dm_ready.
- REQ-034 reset driven low during WAIT of a write of 0xBEEF to 0x0020 -> outputs 0 immediately; a later read of 0x0020 returns the prior value.
- REQ-035 DM_RANGE_CHECK_EN, DEPTH=4096, write to 0x1000 -> dm_err=1 with dm_ready; no array modification; a read of 0x1000 returns 0.
- REQ-036 dm_abus and dm_in_dbus toggled during WAIT -> captured address and data used, confirmed by readback.

Source files
------------

// File: rtl/dm_wait_mem.sv
// dm_wait_mem -- single-port data memory with a fixed number of wait states.
//
// A request (rd_mem or wr_mem) seen in IDLE is captured together with the
// address and write data. After WAIT wait cycles the FSM spends one cycle in
// DONE, pulsing dm_ready. The array write and the read-data load both happen
// on the edge that enters DONE. If rd_mem and wr_mem are both high at
// capture, only the write is performed.
//
// Optional build macro: DM_RANGE_CHECK_EN
//   defined   : addresses >= DEPTH flag dm_err with dm_ready, the write is
//               dropped and a read returns 0.
//   undefined : the address is truncated to the array index width and
//               dm_err is tied to 0.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   rd_mem      in   read request, held until dm_ready
//   wr_mem      in   write request, held until dm_ready
//   dm_abus     in   [AW-1:0] word address
//   dm_in_dbus  in   [DW-1:0] write data
//   dm_out_dbus out  [DW-1:0] registered read data
//   dm_ready    out  one-cycle completion pulse
//   dm_busy     out  high whenever the FSM is not in IDLE
//   dm_err      out  range error
//
// state   | meaning
// IDLE    | waiting for a request; inputs are sampled here only
// WAIT    | counting down wait states on the captured access
// DONE    | access completed this cycle; dm_ready is high
module dm_wait_mem #(
  parameter int AW    = 13,
  parameter int DW    = 16,
  parameter int DEPTH = 8192,
  parameter int WAIT  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_mem,
  input  logic          wr_mem,
  input  logic [AW-1:0] dm_abus,
  input  logic [DW-1:0] dm_in_dbus,
  output logic [DW-1:0] dm_out_dbus,
  output logic          dm_ready,
  output logic          dm_busy,
  output logic          dm_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          cap_wr;

  logic [DW-1:0] mem [DEPTH];

  logic          req;
  logic          enter_done;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_data;
  logic          eff_wr;
  logic [IW-1:0] idx;
  logic          in_range;
  logic          mem_we;
  logic [DW-1:0] rd_data;

  assign req = rd_mem | wr_mem;

  always_comb begin
    enter_done = 1'b0;
    case (state)
      ST_IDLE: enter_done = req && (WAIT_CNT == 4'd0);
      ST_WAIT: enter_done = (cnt == 4'd1);
      default: enter_done = 1'b0;
    endcase
  end

  // With zero wait states DONE is entered on the capture edge itself, so the
  // live bus is used there; otherwise the captured copy is used.
  always_comb begin
    eff_addr = cap_addr;
    eff_data = cap_data;
    eff_wr   = cap_wr;
    if (state == ST_IDLE) begin
      eff_addr = dm_abus;
      eff_data = dm_in_dbus;
      eff_wr   = wr_mem;
    end
  end

  assign idx = eff_addr[IW-1:0];

`ifdef DM_RANGE_CHECK_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  assign in_range = ({1'b0, eff_addr} < DEPTH_W);
`else
  assign in_range = 1'b1;
`endif

  // Reset is folded into the write enable so an edge during reset can never
  // commit an access to the (unreset) array.
  assign mem_we  = enter_done & eff_wr & in_range & reset;
  assign rd_data = mem[idx];

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= eff_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_wr      <= 1'b0;
      dm_out_dbus <= '0;
      dm_ready    <= 1'b0;
      dm_busy     <= 1'b0;
    end else begin
      dm_ready <= enter_done;
      if (enter_done && !eff_wr) dm_out_dbus <= in_range ? rd_data : '0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            cap_addr <= dm_abus;
            cap_data <= dm_in_dbus;
            cap_wr   <= wr_mem;
            cnt      <= WAIT_CNT;
            dm_busy  <= 1'b1;
            state    <= (WAIT_CNT == 4'd0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_DONE;
        end
        default: begin
          state   <= ST_IDLE;
          dm_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DM_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dm_err <= 1'b0;
    else        dm_err <= enter_done & ~in_range;
  end
`else
  assign dm_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_wait_mem.sv
// tb_dm_wait_mem -- directed bench for dm_wait_mem.
// u_dut  : WAIT=2 (default parameters)
// u_dut0 : WAIT=0, used for the back-to-back throughput scenario
// u_dut_r: DEPTH=4096, shares u_dut's inputs, only with DM_RANGE_CHECK_EN
module tb_dm_wait_mem;

  logic        clk = 1'b0;
  logic        reset;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic        a_rd, a_wr;
  logic [12:0] a_abus;
  logic [15:0] a_din, a_out;
  logic        a_ready, a_busy, a_err;

  logic        b_rd, b_wr;
  logic [12:0] b_abus;
  logic [15:0] b_din, b_out;
  logic        b_ready, b_busy, b_err;

  always #5 clk = ~clk;

  dm_wait_mem #(.AW(13), .DW(16), .DEPTH(8192), .WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .rd_mem(a_rd), .wr_mem(a_wr),
    .dm_abus(a_abus), .dm_in_dbus(a_din), .dm_out_dbus(a_out),
    .dm_ready(a_ready), .dm_busy(a_busy), .dm_err(a_err)
  );

  dm_wait_mem #(.AW(13), .DW(16), .DEPTH(8192), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .rd_mem(b_rd), .wr_mem(b_wr),
    .dm_abus(b_abus), .dm_in_dbus(b_din), .dm_out_dbus(b_out),
    .dm_ready(b_ready), .dm_busy(b_busy), .dm_err(b_err)
  );

`ifdef DM_RANGE_CHECK_EN
  logic [15:0] r_out;
  logic        r_ready, r_busy, r_err;
  dm_wait_mem #(.AW(13), .DW(16), .DEPTH(4096), .WAIT(2)) u_dut_r (
    .clk(clk), .reset(reset), .rd_mem(a_rd), .wr_mem(a_wr),
    .dm_abus(a_abus), .dm_in_dbus(a_din), .dm_out_dbus(r_out),
    .dm_ready(r_ready), .dm_busy(r_busy), .dm_err(r_err)
  );
`endif

  // Drives one access on u_dut starting in an IDLE cycle, returns at the
  // negedge of the dm_ready cycle with the request dropped. lat = number of
  // rising edges from capture up to and including the one raising dm_ready,
  // or -1 if dm_ready never came.
  task automatic a_access(input logic rd, input logic wr, input logic [12:0] addr,
                          input logic [15:0] data, output int lat);
    @(negedge clk);
    a_rd = rd; a_wr = wr; a_abus = addr; a_din = data;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_ready) begin
        lat = k;
        break;
      end
    end
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_rd = 0; a_wr = 0; a_abus = '0; a_din = '0;
    b_rd = 0; b_wr = 0; b_abus = '0; b_din = '0;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({a_ready, a_busy, a_err} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_a_flags: got %b expected 000", {a_ready, a_busy, a_err});
    end
    tests_run++;
    if (a_out !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_a_out: got %h expected 0000", a_out);
    end
    tests_run++;
    if ({b_ready, b_busy, b_err, b_out} !== 19'h0) begin
      tests_failed++; $display("FAIL reset_b: got %b/%h expected 000/0000", {b_ready, b_busy, b_err}, b_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (a_busy !== 1'b0) begin
      tests_failed++; $display("FAIL idle_busy: got %b expected 0", a_busy);
    end
  endtask

  task automatic test_write_read;
    int lat;
    a_access(1'b0, 1'b1, 13'h0005, 16'h1234, lat);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++; $display("FAIL wr_latency: got %0d expected 3", lat);
    end
    tests_run++;
    if ({a_busy, a_err} !== 2'b10) begin
      tests_failed++; $display("FAIL wr_done_busy_err: got %b expected 10", {a_busy, a_err});
    end
    @(negedge clk);
    tests_run++;
    if ({a_ready, a_busy} !== 2'b00) begin
      tests_failed++; $display("FAIL ready_pulse: got %b expected 00", {a_ready, a_busy});
    end
    a_access(1'b1, 1'b0, 13'h0005, 16'h0000, lat);
    tests_run++;
    if (lat !== 3) begin
      tests_failed++; $display("FAIL rd_latency: got %0d expected 3", lat);
    end
    tests_run++;
    if (a_out !== 16'h1234) begin
      tests_failed++; $display("FAIL rd_data: got %h expected 1234", a_out);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (a_out !== 16'h1234) begin
      tests_failed++; $display("FAIL rd_hold: got %h expected 1234", a_out);
    end
  endtask

  task automatic test_back_to_back;
    logic        op_wr   [4];
    logic [12:0] op_addr [4];
    logic [15:0] op_data [4];
    int          op;
    logic        exp_ready;
    op_wr[0] = 1; op_addr[0] = 13'h0000; op_data[0] = 16'hAAAA;
    op_wr[1] = 1; op_addr[1] = 13'h0001; op_data[1] = 16'h5555;
    op_wr[2] = 0; op_addr[2] = 13'h0000; op_data[2] = 16'hAAAA;
    op_wr[3] = 0; op_addr[3] = 13'h0001; op_data[3] = 16'h5555;
    op = 0;
    @(negedge clk);
    b_wr = op_wr[0]; b_rd = ~op_wr[0]; b_abus = op_addr[0]; b_din = op_data[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_ready = (c % 2 == 0);
      tests_run++;
      if (b_ready !== exp_ready) begin
        tests_failed++; $display("FAIL b2b_ready cyc %0d: got %b expected %b", c, b_ready, exp_ready);
      end
      if (b_ready === 1'b1 && op < 4) begin
        if (!op_wr[op]) begin
          tests_run++;
          if (b_out !== op_data[op]) begin
            tests_failed++; $display("FAIL b2b_rd op %0d: got %h expected %h", op, b_out, op_data[op]);
          end
        end
        op++;
        if (op < 4) begin
          b_wr = op_wr[op]; b_rd = ~op_wr[op]; b_abus = op_addr[op]; b_din = 16'h9999;
          if (op_wr[op]) b_din = op_data[op];
        end else begin
          b_wr = 0; b_rd = 0;
        end
      end
    end
    tests_run++;
    if (op !== 4 || b_err !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_count: got %0d/%b expected 4/0", op, b_err);
    end
  endtask

  task automatic test_collision;
    int lat;
    a_access(1'b1, 1'b1, 13'h0010, 16'h00FF, lat);
    tests_run++;
    if (lat !== 3 || a_out !== 16'h1234) begin
      tests_failed++; $display("FAIL collide_done: got lat %0d out %h expected 3/1234", lat, a_out);
    end
    a_access(1'b1, 1'b0, 13'h0010, 16'h0000, lat);
    tests_run++;
    if (a_out !== 16'h00FF) begin
      tests_failed++; $display("FAIL collide_readback: got %h expected 00ff", a_out);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    a_access(1'b0, 1'b1, 13'h0020, 16'h1111, lat);
    @(negedge clk);
    a_wr = 1'b1; a_abus = 13'h0020; a_din = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (a_busy !== 1'b1) begin
      tests_failed++; $display("FAIL mid_busy: got %b expected 1", a_busy);
    end
    reset = 1'b0;
    a_wr = 1'b0;
    #1;
    tests_run++;
    if ({a_ready, a_busy, a_err, a_out} !== 19'h0) begin
      tests_failed++; $display("FAIL mid_reset_out: got %b/%h expected 000/0000", {a_ready, a_busy, a_err}, a_out);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({a_ready, a_busy} !== 2'b00) begin
      tests_failed++; $display("FAIL mid_after: got %b expected 00", {a_ready, a_busy});
    end
    a_access(1'b1, 1'b0, 13'h0020, 16'h0000, lat);
    tests_run++;
    if (lat !== 3 || a_out !== 16'h1111) begin
      tests_failed++; $display("FAIL mid_readback: got lat %0d out %h expected 3/1111", lat, a_out);
    end
  endtask

  task automatic test_toggle;
    int lat;
    a_access(1'b0, 1'b1, 13'h0031, 16'h0000, lat);
    @(negedge clk);
    a_wr = 1'b1; a_abus = 13'h0030; a_din = 16'hCAFE;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (a_ready) begin
        lat = k;
        break;
      end
      a_abus = (k % 2 == 1) ? 13'h0031 : 13'h1FFF;
      a_din  = (k % 2 == 1) ? 16'hDEAD : 16'h0F0F;
      a_rd   = 1'b1;
      @(posedge clk);
    end
    a_wr = 1'b0; a_rd = 1'b0;
    tests_run++;
    if (lat !== 3) begin
      tests_failed++; $display("FAIL toggle_latency: got %0d expected 3", lat);
    end
    a_access(1'b1, 1'b0, 13'h0030, 16'h0000, lat);
    tests_run++;
    if (a_out !== 16'hCAFE) begin
      tests_failed++; $display("FAIL toggle_captured: got %h expected cafe", a_out);
    end
    a_access(1'b1, 1'b0, 13'h0031, 16'h0000, lat);
    tests_run++;
    if (a_out !== 16'h0000) begin
      tests_failed++; $display("FAIL toggle_other: got %h expected 0000", a_out);
    end
  endtask

`ifdef DM_RANGE_CHECK_EN
  task automatic test_range;
    int lat;
    a_access(1'b0, 1'b1, 13'h1000, 16'h7777, lat);
    tests_run++;
    if ({r_ready, r_err} !== 2'b11) begin
      tests_failed++; $display("FAIL range_wr_err: got %b expected 11", {r_ready, r_err});
    end
    @(negedge clk);
    tests_run++;
    if (r_err !== 1'b0) begin
      tests_failed++; $display("FAIL range_err_pulse: got %b expected 0", r_err);
    end
    a_access(1'b1, 1'b0, 13'h1000, 16'h0000, lat);
    tests_run++;
    if ({r_ready, r_err} !== 2'b11 || r_out !== 16'h0000) begin
      tests_failed++; $display("FAIL range_rd: got %b/%h expected 11/0000", {r_ready, r_err}, r_out);
    end
    a_access(1'b1, 1'b0, 13'h0000, 16'h0000, lat);
    tests_run++;
    if (r_err !== 1'b0 || r_out === 16'h7777) begin
      tests_failed++; $display("FAIL range_alias: got %b/%h expected 0/not 7777", r_err, r_out);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_collision;
    test_reset_mid;
    test_toggle;
`ifdef DM_RANGE_CHECK_EN
    test_range;
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
